// File: rtl/acq_ctrl_pkg.sv
// Shared sizing and state encoding for the coherent accumulation sequencer.
package acq_ctrl_pkg;

  localparam int unsigned COH_DATA_NUMBER = 682;
  localparam int unsigned CNT_W           = 6;
  localparam int unsigned DRAIN_CYCLES    = 6;
  localparam int unsigned TIMEOUT         = 1023;
  localparam int unsigned EXP_W           = 4;
  localparam int unsigned RES_W           = $clog2(COH_DATA_NUMBER + 1);
  localparam int unsigned TMO_W           = $clog2(TIMEOUT + 1);
  localparam int unsigned DRN_W           = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KICK    = 3'd1,
    S_COLLECT = 3'd2,
    S_DRAIN   = 3'd3,
    S_CHECK   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // A programmed count of zero runs a single iteration.
  function automatic logic [CNT_W-1:0] norm_count(input logic [CNT_W-1:0] n);
    return (n == '0) ? CNT_W'(1) : n;
  endfunction

endpackage

// File: rtl/acq_pass_counter.sv
// Counts correlation results within one matched-filter pass; flags the terminal
// result and any strobe arriving while the pass is draining.
module acq_pass_counter
  import acq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic count_en,
  input  logic over_en,
  input  logic valid,
  output logic first_c,
  output logic last_c,
  output logic overrun_c
);

  logic [RES_W-1:0] res_cnt_q;
  logic [RES_W-1:0] res_cnt_d;

  always_comb begin
    res_cnt_d = res_cnt_q;
    if (clr) begin
      res_cnt_d = '0;
    end else if (count_en && valid) begin
      res_cnt_d = res_cnt_q + RES_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt_q <= '0;
    end else begin
      res_cnt_q <= res_cnt_d;
    end
  end

  // first_c is combinational so it coincides with the first strobe of the pass.
  assign first_c   = count_en && (res_cnt_q == '0);
  assign last_c    = count_en && valid && (res_cnt_q == RES_W'(COH_DATA_NUMBER - 1));
  assign overrun_c = over_en && valid;

endmodule

// File: rtl/coh_acc_ctrl.sv
// Sequencer for the coherent accumulation datapath: runs seg x coh matched-filter
// passes, waits for coh_acc write-back between passes and reports completion.
module coh_acc_ctrl
  import acq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] seg_number,
  input  logic [CNT_W-1:0] coh_number,
  output logic             mf_start,
  input  logic             cor_result_valid,
  output logic             first_result,
  output logic             first_segment,
  output logic             first_acc,
  input  logic             write_finish,
  input  logic [EXP_W-1:0] max_exp_in,
  output logic             busy,
  output logic             round_done,
  output logic             done,
  output logic [EXP_W-1:0] max_exp_out,
  output logic             err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] seg_n_q, seg_n_d;
  logic [CNT_W-1:0] coh_n_q, coh_n_d;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
  logic [CNT_W-1:0] coh_cnt_q, coh_cnt_d;
  logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [EXP_W-1:0] max_exp_q, max_exp_d;
  logic             mf_start_q, mf_start_d;
  logic             first_segment_q, first_segment_d;
  logic             first_acc_q, first_acc_d;
  logic             busy_q, busy_d;
  logic             round_done_q, round_done_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             res_clr_c;
  logic             res_count_en_c;
  logic             res_over_en_c;
  logic             res_first_c;
  logic             res_last_c;
  logic             res_overrun_c;
  logic             tmo_hit_c;

  assign res_clr_c      = (state_q == S_KICK) || abort;
  assign res_count_en_c = (state_q == S_COLLECT);
  assign res_over_en_c  = (state_q == S_DRAIN);
  assign tmo_hit_c      = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

  acq_pass_counter u_pass_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (res_clr_c),
    .count_en  (res_count_en_c),
    .over_en   (res_over_en_c),
    .valid     (cor_result_valid),
    .first_c   (res_first_c),
    .last_c    (res_last_c),
    .overrun_c (res_overrun_c)
  );

  // Next-state, loop counters and registered output decodes.
  always_comb begin
    state_d      = state_q;
    seg_n_d      = seg_n_q;
    coh_n_d      = coh_n_q;
    seg_cnt_d    = seg_cnt_q;
    coh_cnt_d    = coh_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    tmo_cnt_d    = '0;
    max_exp_d    = max_exp_q;
    err_d        = err_q;
    round_done_d = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          seg_n_d   = norm_count(seg_number);
          coh_n_d   = norm_count(coh_number);
          seg_cnt_d = '0;
          coh_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = S_KICK;
        end
      end
      S_KICK: begin
        state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (res_last_c) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end else if (tmo_hit_c && !cor_result_valid) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // write_finish is still high from the previous pass here, so it is not looked at yet.
        drain_cnt_d = drain_cnt_q + DRN_W'(1);
        if (res_overrun_c) begin
          err_d = 1'b1;
        end
        if (drain_cnt_q == DRN_W'(DRAIN_CYCLES - 1)) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (write_finish) begin
          if (seg_cnt_q < seg_n_q - CNT_W'(1)) begin
            seg_cnt_d = seg_cnt_q + CNT_W'(1);
            state_d   = S_KICK;
          end else begin
            seg_cnt_d    = '0;
            max_exp_d    = max_exp_in;
            round_done_d = 1'b1;
            if (coh_cnt_q < coh_n_q - CNT_W'(1)) begin
              coh_cnt_d = coh_cnt_q + CNT_W'(1);
              state_d   = S_KICK;
            end else begin
              state_d = S_DONE;
            end
          end
        end else if (tmo_hit_c) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d      = S_IDLE;
      seg_cnt_d    = '0;
      coh_cnt_d    = '0;
      drain_cnt_d  = '0;
      max_exp_d    = max_exp_q;
      err_d        = err_q;
      round_done_d = 1'b0;
      done_d       = 1'b0;
    end

    // The no-progress timer restarts on every state change and every counted strobe.
    if ((state_d != state_q) || ((state_q == S_COLLECT) && cor_result_valid)) begin
      tmo_cnt_d = '0;
    end else if ((state_q == S_COLLECT) || (state_q == S_CHECK)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    mf_start_d      = (state_d == S_KICK);
    busy_d          = (state_d != S_IDLE);
    first_segment_d = (seg_cnt_d == '0);
    first_acc_d     = (coh_cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      seg_n_q         <= '0;
      coh_n_q         <= '0;
      seg_cnt_q       <= '0;
      coh_cnt_q       <= '0;
      drain_cnt_q     <= '0;
      tmo_cnt_q       <= '0;
      max_exp_q       <= '0;
      mf_start_q      <= 1'b0;
      first_segment_q <= 1'b0;
      first_acc_q     <= 1'b0;
      busy_q          <= 1'b0;
      round_done_q    <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      seg_n_q         <= seg_n_d;
      coh_n_q         <= coh_n_d;
      seg_cnt_q       <= seg_cnt_d;
      coh_cnt_q       <= coh_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      max_exp_q       <= max_exp_d;
      mf_start_q      <= mf_start_d;
      first_segment_q <= first_segment_d;
      first_acc_q     <= first_acc_d;
      busy_q          <= busy_d;
      round_done_q    <= round_done_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign mf_start      = mf_start_q;
  assign first_result  = res_first_c;
  assign first_segment = first_segment_q;
  assign first_acc     = first_acc_q;
  assign busy          = busy_q;
  assign round_done    = round_done_q;
  assign done          = done_q;
  assign max_exp_out   = max_exp_q;
  assign err           = err_q;

endmodule
